fine_scroll_seq: RTL and testbench

Sequencer that drives the four per-plane 4-bit pixel shifters of a tilemap layer. It accepts 8-pixel, 4-plane tile row words from the tile fetcher over a valid/ready handshake and splits each word into nibbles. It then issues the shifter mode code (load / shift / hold) on every pixel enable, applying fine X scroll and optional horizontal flip. It sits between the tile fetch logic and the shifters, and marks which shifter output bit carries the current pixel.

---
 rtl/tmnt_gfx_pkg.sv | 34 +++
 rtl/tile_word_buf.sv | 56 +++++
 rtl/fine_scroll_seq.sv | 194 +++++++++++++++++++
 tb/tb_fine_scroll_seq.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/tmnt_gfx_pkg.sv
// Shared tilemap graphics definitions: shifter mode codes, sequencer states
// and the tile-row nibble extraction helper.
package tmnt_gfx_pkg;

    // Mode code presented to the four per-plane 4-bit pixel shifters.
    typedef enum logic [1:0] {
        SEL_LOAD = 2'b00,
        SEL_SHR  = 2'b01,   // shift toward bit 0
        SEL_SHL  = 2'b10,   // shift toward bit 3
        SEL_HOLD = 2'b11
    } sel_e;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DISCARD,
        RUN
    } state_e;

    localparam int PLANES = 4;

    // Pick one 4-pixel half of every plane byte: low_half selects bits [3:0],
    // otherwise bits [7:4]. Plane p lands on nibble p of the result.
    function automatic logic [15:0] tile_nibbles(input logic [31:0] word,
                                                 input logic        low_half);
        logic [15:0] nib;
        nib = '0;
        for (int p = 0; p < PLANES; p++) begin
            nib[4*p +: 4] = low_half ? word[8*p +: 4] : word[8*p+4 +: 4];
        end
        return nib;
    endfunction

endpackage

// File: rtl/tile_word_buf.sv
// One-entry valid/ready buffer for tile row words. Besides the word it keeps
// the FLIP bit captured with it and a half flag telling whether the first
// nibble has already been consumed.
module tile_word_buf (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,         // acceptance allowed (sequencer not idle)
    input  logic [31:0] tw,
    input  logic        tw_valid,
    input  logic        flip,
    input  logic        vacate,     // second nibble read this cycle
    input  logic        advance,    // first nibble read this cycle
    input  logic        flush,      // drop any held word
    output logic        tw_ready,
    output logic        valid,
    output logic [31:0] word,
    output logic        word_flip,
    output logic        half
);

    logic accept;

    // A vacating read frees the slot in the same cycle, so refill has no bubble.
    assign tw_ready = en && (!valid || vacate);
    assign accept   = tw_valid && tw_ready;

    // Occupancy, captured flip and half-consumed tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid     <= 1'b0;
            half      <= 1'b0;
            word_flip <= 1'b0;
        end else if (flush) begin
            valid <= 1'b0;
            half  <= 1'b0;
        end else if (accept) begin
            valid     <= 1'b1;
            half      <= 1'b0;
            word_flip <= flip;
        end else if (vacate) begin
            valid <= 1'b0;
            half  <= 1'b0;
        end else if (advance) begin
            half <= 1'b1;
        end
    end

    // Word payload capture.
    // NOTE: the payload has no reset; it is only ever read while valid is set.
    always_ff @(posedge clk) begin
        if (accept && !flush) begin
            word <= tw;
        end
    end

endmodule

// File: rtl/fine_scroll_seq.sv
// Fine X scroll sequencer for the four per-plane tilemap pixel shifters.
// Splits buffered tile row words into nibbles and issues load/shift/hold codes
// per pixel enable, applying fine scroll on line start.
// Optional horizontal flip is enabled by defining FINE_SCROLL_FLIP_EN; without
// it FLIP is ignored, SEL never shows the toward-bit-3 code and TAP3 stays 0.
module fine_scroll_seq
    import tmnt_gfx_pkg::*;
#(
    parameter int LINE_PIX = 320
) (
    input  logic        CLK,
    input  logic        nRESET,
    input  logic        HSTART,
    input  logic        PE,
    input  logic [2:0]  FSCROLL,
    input  logic        FLIP,
    input  logic [31:0] TW,
    input  logic        TW_VALID,
    output logic        TW_READY,
    output logic [1:0]  SEL,
    output logic [15:0] DIN,
    output logic        TAP3,
    output logic        PIX_VALID,
    output logic        UNDERRUN
);

    localparam logic [8:0] LAST_PIX = 9'(LINE_PIX - 1);

    state_e      state_q, state_d;
    logic [2:0]  fs_q, fs_d;
    logic [1:0]  phase_q, phase_d;
    logic [1:0]  dcnt_q, dcnt_d;
    logic [8:0]  pix_q, pix_d;
    sel_e        sel_q, sel_d;
    logic [15:0] din_q, din_d;
    logic        tap3_q, tap3_d;
    logic        pv_q, pv_d;
    logic        und_q, und_d;

    logic        do_load, load_second, flush;
    logic        buf_vacate, buf_advance;
    logic        buf_valid, buf_half, buf_flip;
    logic [31:0] buf_word;
    logic        flip_in;
    sel_e        shift_code;

`ifdef FINE_SCROLL_FLIP_EN
    assign flip_in    = FLIP;
    assign shift_code = tap3_q ? SEL_SHL : SEL_SHR;
    assign TAP3       = tap3_q;
`else
    logic unused_flip;
    assign unused_flip = FLIP ^ tap3_q;
    assign flip_in     = 1'b0;
    assign shift_code  = SEL_SHR;
    assign TAP3        = 1'b0;
`endif

    // A buffer read only consumes a nibble when a word is actually held.
    assign buf_vacate  = do_load && buf_valid && load_second;
    assign buf_advance = do_load && buf_valid && !load_second;

    tile_word_buf u_buf (
        .clk       (CLK),
        .rst_n     (nRESET),
        .en        (state_q != IDLE),
        .tw        (TW),
        .tw_valid  (TW_VALID),
        .flip      (flip_in),
        .vacate    (buf_vacate),
        .advance   (buf_advance),
        .flush     (flush),
        .tw_ready  (TW_READY),
        .valid     (buf_valid),
        .word      (buf_word),
        .word_flip (buf_flip),
        .half      (buf_half)
    );

    // Next-state, counters and next registered shifter controls.
    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        state_d     = state_q;
        fs_d        = fs_q;
        phase_d     = phase_q;
        dcnt_d      = dcnt_q;
        pix_d       = pix_q;
        sel_d       = SEL_HOLD;
        din_d       = din_q;
        tap3_d      = tap3_q;
        pv_d        = 1'b0;
        und_d       = und_q;
        do_load     = 1'b0;
        load_second = 1'b0;
        flush       = 1'b0;

        case (state_q)
            IDLE: begin
                if (HSTART) begin
                    fs_d    = FSCROLL;
                    und_d   = 1'b0;
                    pix_d   = '0;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                // Coarse part of the scroll: FSCROLL[2] skips the first nibble.
                if (buf_valid) begin
                    do_load     = 1'b1;
                    load_second = fs_q[2];
                    dcnt_d      = '0;
                    phase_d     = fs_q[1:0];
                    state_d     = DISCARD;
                end
            end
            DISCARD: begin
                // Free-running shifts drop FSCROLL[1:0] pixels before display.
                if (dcnt_q != fs_q[1:0]) begin
                    sel_d  = shift_code;
                    dcnt_d = dcnt_q + 2'd1;
                    if (dcnt_q + 2'd1 == fs_q[1:0]) begin
                        state_d = RUN;
                    end
                end else begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (PE) begin
                    pv_d  = 1'b1;
                    pix_d = pix_q + 9'd1;
                    if (pix_q == LAST_PIX) begin
                        state_d = IDLE;
                        flush   = 1'b1;
                    end else if (phase_q == 2'd3) begin
                        do_load     = 1'b1;
                        load_second = buf_half;
                        phase_d     = 2'd0;
                    end else begin
                        sel_d   = shift_code;
                        phase_d = phase_q + 2'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // An empty buffer at load time loads transparent pixels and flags it.
        if (do_load) begin
            sel_d = SEL_LOAD;
            if (buf_valid) begin
                din_d  = tile_nibbles(buf_word, load_second ^ buf_flip);
                tap3_d = buf_flip;
            end else begin
                din_d = '0;
                und_d = 1'b1;
            end
        end
    end

    // State and registered outputs.
    always_ff @(posedge CLK or negedge nRESET) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (!nRESET) begin
            state_q <= IDLE;
            fs_q    <= '0;
            phase_q <= '0;
            dcnt_q  <= '0;
            pix_q   <= '0;
            sel_q   <= SEL_HOLD;
            din_q   <= '0;
            tap3_q  <= 1'b0;
            pv_q    <= 1'b0;
            und_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            fs_q    <= fs_d;
            phase_q <= phase_d;
            dcnt_q  <= dcnt_d;
            pix_q   <= pix_d;
            sel_q   <= sel_d;
            din_q   <= din_d;
            tap3_q  <= tap3_d;
            pv_q    <= pv_d;
            und_q   <= und_d;
        end
    end

    assign SEL       = sel_q;
    assign DIN       = din_q;
    assign PIX_VALID = pv_q;
    assign UNDERRUN  = und_q;

endmodule

// File: tb/tb_fine_scroll_seq.sv
// Scoreboard bench for fine_scroll_seq. A line-level reference model computes
// the sequence of shifter operations from pixel-position arithmetic; a monitor
// compares each non-hold shifter operation the DUT issues against it.
module tb_fine_scroll_seq;
    import tmnt_gfx_pkg::*;

    localparam int          LP = 16;
    localparam logic [31:0] W0 = 32'hF0A5_3C81;
`ifdef FINE_SCROLL_FLIP_EN
    localparam bit FLIP_EN = 1'b1;
`else
    localparam bit FLIP_EN = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        nRESET, HSTART, PE, FLIP, TW_VALID;
    logic [2:0]  FSCROLL;
    logic [31:0] TW;
    logic        TW_READY, TAP3, PIX_VALID, UNDERRUN;
    logic [1:0]  SEL;
    logic [15:0] DIN;

    always #5 CLK = ~CLK;

    fine_scroll_seq #(.LINE_PIX(LP)) dut (
        .CLK(CLK), .nRESET(nRESET), .HSTART(HSTART), .PE(PE), .FSCROLL(FSCROLL),
        .FLIP(FLIP), .TW(TW), .TW_VALID(TW_VALID), .TW_READY(TW_READY),
        .SEL(SEL), .DIN(DIN), .TAP3(TAP3), .PIX_VALID(PIX_VALID), .UNDERRUN(UNDERRUN)
    );

    typedef struct packed {
        logic [1:0]  sel;
        logic [15:0] din;
        logic        tap;
    } ev_t;

    int          n_cmp = 0;
    int          n_bad = 0;
    ev_t         exp_q[$];
    logic [31:0] line_w[$];
    bit          line_f[$];
    logic [31:0] sup_w[$];
    bit          sup_f[$];
    int          sup_idx = 0;
    int          pix_cnt = 0;
    int          mon_op  = 0;
    bit          mon_en  = 1'b0;
    bit          pe_cont = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Plane p nibble from byte p: low half is pixels 4..7, high half pixels 0..3.
    function automatic logic [15:0] ref_row(input logic [31:0] w, input bit low);
        logic [15:0] r;
        r = '0;
        for (int p = 0; p < 4; p++) begin
            r = r | 16'(((w >> (8*p + (low ? 0 : 4))) & 32'hF) << (4*p));
        end
        return r;
    endfunction

    function automatic bit eff_flip(input bit f);
        return f & FLIP_EN;
    endfunction

    // Operation n of a line addresses pixel position n of the scrolled nibble
    // stream: positions divisible by 4 start a new nibble (load), others shift.
    // Nibble stream index = FSCROLL[2] + n/4; words past the supply are empty.
    task automatic model_line(input logic [2:0] fs, output logic und);
        ev_t cur;
        int  s;
        cur = '0;
        und = 1'b0;
        for (int op = 0; op < int'(fs[1:0]) + LP; op++) begin
            if (op % 4 == 0) begin
                s       = int'(fs[2]) + op / 4;
                cur.sel = SEL_LOAD;
                if (s / 2 < line_w.size()) begin
                    cur.tap = eff_flip(line_f[s/2]);
                    cur.din = ref_row(line_w[s/2], ((s % 2) == 1) ^ cur.tap);
                end else begin
                    cur.din = '0;
                    und     = 1'b1;
                end
            end else begin
                cur.sel = cur.tap ? SEL_SHL : SEL_SHR;
            end
            exp_q.push_back(cur);
        end
    endtask

    // Tile fetcher: presents the supply queue in order, advancing on handshake.
    initial begin
        bit hs;
        TW = '0; TW_VALID = 1'b0; FLIP = 1'b0;
        forever begin
            @(negedge CLK);
            hs = TW_VALID && TW_READY;
            @(posedge CLK);
            #1;
            if (hs) sup_idx++;
            if (sup_idx < sup_w.size()) begin
                TW_VALID = 1'b1;
                TW       = sup_w[sup_idx];
                FLIP     = sup_f[sup_idx];
            end else begin
                TW_VALID = 1'b0;
                TW       = $urandom;
                FLIP     = 1'($urandom_range(0, 1));
            end
        end
    end

    // Pixel enable: continuous or random, driven the whole time.
    initial begin
        PE = 1'b0;
        forever begin
            @(posedge CLK);
            #1;
            PE = pe_cont ? 1'b1 : ($urandom_range(0, 2) != 0);
        end
    end

    // Monitor: count pixels and check each issued shifter operation.
    always @(negedge CLK) begin
        ev_t e;
        if (mon_en && nRESET) begin
            if (PIX_VALID) pix_cnt++;
            if (SEL != SEL_HOLD) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL op_extra: sel=%b din=%h tap3=%b issued, none expected", SEL, DIN, TAP3);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("op%0d {sel,din,tap3}", mon_op), 32'({SEL, DIN, TAP3}), 32'(e));
                end
                mon_op++;
            end
        end
    end

    task automatic run_line(input logic [2:0] fs, input int nw, input int flip_mode,
                            input bit use_w0, input bit cont, input int abort_at);
        logic und_exp;
        line_w.delete();
        line_f.delete();
        for (int i = 0; i < nw; i++) begin
            line_w.push_back((use_w0 && i == 0) ? W0 : $urandom);
            line_f.push_back(flip_mode == 2 ? bit'($urandom_range(0, 1)) : bit'(flip_mode == 1));
        end
        pe_cont = cont;
        @(negedge CLK);
        sup_w   = line_w;
        sup_f   = line_f;
        sup_idx = 0;
        model_line(fs, und_exp);
        pix_cnt = 0;
        mon_op  = 0;
        @(posedge CLK); #1;
        HSTART = 1'b1; FSCROLL = fs;
        @(posedge CLK); #1;
        HSTART = 1'b0; FSCROLL = 3'($urandom);
        @(negedge CLK);
        check("underrun_cleared", UNDERRUN, 0);
        if (abort_at > 0) begin
            for (int c = 0; c < 3000 && pix_cnt < abort_at; c++) @(negedge CLK);
            check("abort_point_reached", 32'(pix_cnt >= abort_at), 1);
            #2;
            nRESET = 1'b0;
            mon_en = 1'b0;
            #1;
            check("rst_sel", SEL, SEL_HOLD);
            check("rst_din", DIN, 0);
            check("rst_tap3", TAP3, 0);
            check("rst_pix_valid", PIX_VALID, 0);
            check("rst_underrun", UNDERRUN, 0);
            check("rst_tw_ready", TW_READY, 0);
            exp_q.delete();
            sup_w.delete();
            sup_f.delete();
            sup_idx = 0;
            repeat (3) @(negedge CLK);
            nRESET = 1'b1;
            mon_en = 1'b1;
        end else begin
            for (int c = 0; c < 3000 && pix_cnt < LP; c++) @(negedge CLK);
            repeat (12) @(negedge CLK);
            check("pix_valid_count", pix_cnt, LP);
            check("ops_outstanding", exp_q.size(), 0);
            check("underrun_flag", UNDERRUN, und_exp);
            check("idle_sel", SEL, SEL_HOLD);
            check("idle_tw_ready", TW_READY, 0);
            exp_q.delete();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        nRESET = 1'b0; HSTART = 1'b0; FSCROLL = '0;
        repeat (3) @(negedge CLK);
        nRESET = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            check("idle_sel", SEL, SEL_HOLD);
            check("idle_din", DIN, 0);
            check("idle_pix_valid", PIX_VALID, 0);
            check("idle_tw_ready", TW_READY, 0);
        end
        mon_en = 1'b1;

        run_line(3'd0, 4, 0, 1'b1, 1'b1, 0);   // plain line, known word
        run_line(3'd5, 4, 0, 1'b1, 1'b1, 0);   // coarse skip + one discard shift
        run_line(3'd0, 4, 1, 1'b1, 1'b1, 0);   // flipped words
        run_line(3'd0, 1, 0, 1'b1, 1'b1, 0);   // supply runs dry -> underrun
        run_line(3'd3, 4, 0, 1'b1, 1'b1, 0);   // clears underrun, max discard
        run_line(3'd7, 3, 1, 1'b0, 1'b0, 0);
        for (int i = 0; i < 24; i++) begin
            run_line(3'($urandom), $urandom_range(1, 4), 2, 1'b0, 1'b0, 0);
        end
        run_line(3'd0, 1, 1, 1'b1, 1'b1, 11);  // reset mid-line after underrun
        run_line(3'd2, 4, 2, 1'b0, 1'b0, 0);   // recovery after reset

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
